// File: rtl/x25519_pkg.sv
// Constants and FSM state encoding shared by the req/res field-arithmetic units.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package x25519_pkg;

  // Field prime 2^255 - 19
  localparam logic [254:0] P25519 = {{247{1'b1}}, 8'hED};

  // Common req/res unit states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/multmod_digit_modstep.sv
// One radix-2 interleaved modular multiplication step: acc' = (2*acc + xbit*y) mod m.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module modstep #(
  parameter int N = 255
) (
  input  logic [N+1:0] acc,
  input  logic [N-1:0] y,
  input  logic [N-1:0] m,
  input  logic         xbit,
  output logic [N+1:0] acc_nxt
);

  logic [N+1:0] m_ext;
  logic [N+1:0] y_ext;
  logic [N+1:0] t0;
  logic [N+1:0] t1;
  logic [N+1:0] t2;

  // Double, add the selected multiplicand, then fold back below m.
  // With acc < m and y < m the sum stays under 3m, so two conditional
  // subtractions are always enough.
  always_comb begin
    m_ext   = {2'b00, m};
    y_ext   = xbit ? {2'b00, y} : '0;
    t0      = (acc << 1) + y_ext;
    t1      = (t0 >= m_ext) ? (t0 - m_ext) : t0;
    t2      = (t1 >= m_ext) ? (t1 - m_ext) : t1;
    acc_nxt = t2;
  end

endmodule

// File: rtl/multmod_digit.sv
// Interleaved modular multiplier Z = (X*Y) mod M, D multiplier bits (MSB first) per clock.
// Latency: N/D clocks from the accept edge to res_valid.
// Backpressure: result held in DONE until res_ready; req_valid ignored outside IDLE.
module multmod_digit #(
  parameter int N = 255,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic [N-1:0] M,
  output logic [N-1:0] Z,
  input  logic         req_valid,
  output logic         req_ready,
  output logic         req_busy,
  output logic         res_valid,
  input  logic         res_ready
);
  import x25519_pkg::*;

  localparam int L  = N / D;
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  // Reject digit sizes that do not tile the operand exactly.
  if (((N % D) != 0) || (D < 1) || (D > 8)) begin : g_bad_param
    $error("multmod_digit: D must be in 1..8 and divide N");
  end

  state_e         state_q, state_d;
  logic [N-1:0]   x_q, x_d;
  logic [N-1:0]   y_q, y_d;
  logic [N-1:0]   m_q, m_d;
  logic [N-1:0]   z_q, z_d;
  logic [N+1:0]   acc_q, acc_d;
  logic [N+1:0]   acc_fin;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           req_ready_q, req_ready_d;
  logic           req_busy_q, req_busy_d;
  logic           res_valid_q, res_valid_d;

  // Chain of D single-bit steps; step i consumes x bit N-1-i of the current digit.
  for (genvar i = 0; i < D; i++) begin : g_step
    logic [N+1:0] acc_in;
    logic [N+1:0] acc_out;
    if (i == 0) begin : g_first
      assign acc_in = acc_q;
    end else begin : g_next
      assign acc_in = g_step[i-1].acc_out;
    end
    modstep #(.N(N)) u_step (
      .acc    (acc_in),
      .y      (y_q),
      .m      (m_q),
      .xbit   (x_q[N-1-i]),
      .acc_nxt(acc_out)
    );
  end

  assign acc_fin = g_step[D-1].acc_out;

  // Next-state and datapath update for the IDLE -> BUSY -> DONE handshake.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    m_d         = m_q;
    z_d         = z_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    req_busy_d  = req_busy_q;
    res_valid_d = res_valid_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          x_d         = X;
          y_d         = Y;
          m_d         = M;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = BUSY;
          req_ready_d = 1'b0;
          req_busy_d  = 1'b1;
        end
      end
      BUSY: begin
        acc_d = acc_fin;
        x_d   = x_q << D;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          z_d         = acc_fin[N-1:0];
          state_d     = DONE;
          req_busy_d  = 1'b0;
          res_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        req_busy_d  = 1'b0;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // State, operands and registered handshake outputs; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      m_q         <= '0;
      z_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      req_busy_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      m_q         <= m_d;
      z_q         <= z_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      req_busy_q  <= req_busy_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign Z         = z_q;
  assign req_ready = req_ready_q;
  assign req_busy  = req_busy_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_multmod_digit.sv
// Bench for multmod_digit: three instances (N=8/D=2, N=255/D=1, N=255/D=5),
// a cycle-level reference model of the handshake plus arithmetic golden values,
// and directed vectors with hand-computed results.
module tb_multmod_digit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [254:0] xi [3];
  logic [254:0] yi [3];
  logic [254:0] mi [3];
  logic         rqv [3];
  logic         rsr [3];

  wire [7:0]   za;
  wire [254:0] zb, zc;
  wire         rr0, rr1, rr2, rb0, rb1, rb2, sv0, sv1, sv2;

  logic [254:0] z_o [3];
  logic         rr_o [3];
  logic         rb_o [3];
  logic         sv_o [3];
  assign z_o[0] = {247'd0, za};
  assign z_o[1] = zb;
  assign z_o[2] = zc;
  assign rr_o[0] = rr0; assign rr_o[1] = rr1; assign rr_o[2] = rr2;
  assign rb_o[0] = rb0; assign rb_o[1] = rb1; assign rb_o[2] = rb2;
  assign sv_o[0] = sv0; assign sv_o[1] = sv1; assign sv_o[2] = sv2;

  multmod_digit #(.N(8), .D(2)) u_a (
    .clk(clk), .rst(rst), .X(xi[0][7:0]), .Y(yi[0][7:0]), .M(mi[0][7:0]), .Z(za),
    .req_valid(rqv[0]), .req_ready(rr0), .req_busy(rb0), .res_valid(sv0), .res_ready(rsr[0]));
  multmod_digit #(.N(255), .D(1)) u_b (
    .clk(clk), .rst(rst), .X(xi[1]), .Y(yi[1]), .M(mi[1]), .Z(zb),
    .req_valid(rqv[1]), .req_ready(rr1), .req_busy(rb1), .res_valid(sv1), .res_ready(rsr[1]));
  multmod_digit #(.N(255), .D(5)) u_c (
    .clk(clk), .rst(rst), .X(xi[2]), .Y(yi[2]), .M(mi[2]), .Z(zc),
    .req_valid(rqv[2]), .req_ready(rr2), .req_busy(rb2), .res_valid(sv2), .res_ready(rsr[2]));

  localparam logic [255:0] PW = (256'd1 << 255) - 256'd19;
  localparam logic [254:0] P  = PW[254:0];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b,
                                          input logic [254:0] m);
    logic [509:0] p;
    logic [509:0] r;
    if (m == '0) return '0;
    p = {255'd0, a} * {255'd0, b};
    r = p % {255'd0, m};
    return r[254:0];
  endfunction

  // Reference model: 0 = idle, 1 = busy, 2 = done; result appears after lat_of edges.
  int           st [3];
  int           cnt [3];
  logic [254:0] ez [3];
  logic [254:0] pend [3];
  int           lat_of [3] = '{4, 255, 51};
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        st[k] = 0;
        ez[k] = '0;
      end else begin
        case (st[k])
          0: if (rqv[k]) begin
               pend[k] = mulmod(xi[k], yi[k], mi[k]);
               cnt[k]  = 0;
               st[k]   = 1;
             end
          1: begin
               cnt[k]++;
               if (cnt[k] == lat_of[k]) begin
                 ez[k] = pend[k];
                 st[k] = 2;
               end
             end
          default: if (rsr[k]) st[k] = 0;
        endcase
      end
    end
    if (!rst) chk_en = 1'b1;
  end

  // Every cycle after the first reset: all outputs of all instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        logic [257:0] exp_v, act_v;
        exp_v = {st[k] == 0, st[k] == 1, st[k] == 2, ez[k]};
        act_v = {rr_o[k], rb_o[k], sv_o[k], z_o[k]};
        n_cmp++;
        if (act_v !== exp_v) begin
          n_bad++;
          $display("FAIL cycle dut%0d t=%0t got %0h want %0h", k, $time, act_v, exp_v);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [254:0] act, input logic [254:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask

  // Called at a negedge with the instance idle; returns at a negedge
  // (the res_valid one if res_ready is low, one later otherwise).
  task automatic do_op(input int k, input logic [254:0] x, input logic [254:0] y,
                       input logic [254:0] m, output int lat, output int busy,
                       output logic [254:0] z);
    xi[k] = x; yi[k] = y; mi[k] = m; rqv[k] = 1'b1;
    @(negedge clk);
    rqv[k] = 1'b0;
    lat = 0;
    busy = 0;
    while (!sv_o[k] && lat < 600) begin
      busy += int'(rb_o[k]);
      @(negedge clk);
      lat++;
    end
    z = z_o[k];
    if (rsr[k]) @(negedge clk);
  endtask

  initial begin
    int lat, busy;
    logic [254:0] z, x, y;
    logic [255:0] r;

    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      xi[k] = '0; yi[k] = '0; mi[k] = '0; rqv[k] = 1'b0; rsr[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_flags%0d", k), {252'd0, rr_o[k], rb_o[k], sv_o[k]}, 255'b100);
      check($sformatf("reset_z%0d", k), z_o[k], '0);
    end

    // 1: small instance, 200*100 mod 251
    do_op(0, 255'd200, 255'd100, 255'd251, lat, busy, z);
    check("t1_z", z, 255'd171);
    check("t1_lat", 255'(lat), 255'd4);

    // 2: D=1 over P25519
    x = '0; x[254] = 1'b1;
    do_op(1, x, 255'd2, P, lat, busy, z);
    check("t2_z_19", z, 255'd19);
    check("t2_lat", 255'(lat), 255'd255);
    do_op(1, P - 255'd1, P - 255'd1, P, lat, busy, z);
    check("t2_z_1", z, 255'd1);

    // 3: D=5 random operands, Y < P
    do_op(2, x, 255'd2, P, lat, busy, z);
    check("t3_z_19", z, 255'd19);
    for (int i = 0; i < 500; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      x = r[254:0];
      r = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      y = r[254:0];
      if (y >= P) y = y - P;
      do_op(2, x, y, P, lat, busy, z);
      check("t3_z", z, mulmod(x, y, P));
      check("t3_lat", 255'(lat), 255'd51);
      check("t3_busy", 255'(busy), 255'd51);
    end

    // 4: hold the result for 5 cycles while poking req_valid
    rsr[0] = 1'b0;
    do_op(0, 255'd7, 255'd9, 255'd251, lat, busy, z);
    check("t4_z", z, 255'd63);
    for (int i = 0; i < 5; i++) begin
      rqv[0] = ~rqv[0];
      @(negedge clk);
      check("t4_hold_flags", {252'd0, rr_o[0], rb_o[0], sv_o[0]}, 255'b001);
      check("t4_hold_z", z_o[0], 255'd63);
    end
    rqv[0] = 1'b0;
    rsr[0] = 1'b1;
    @(negedge clk);
    check("t4_idle_flags", {252'd0, rr_o[0], rb_o[0], sv_o[0]}, 255'b100);
    do_op(0, 255'd20, 255'd30, 255'd251, lat, busy, z);
    check("t4_b2b_z", z, 255'd98);
    check("t4_b2b_lat", 255'(lat), 255'd4);

    // 5: reset asserted for one edge at cnt = 2
    xi[0] = 255'd100; yi[0] = 255'd100; mi[0] = 255'd251; rqv[0] = 1'b1;
    @(negedge clk);
    rqv[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("t5_flags", {252'd0, rr_o[0], rb_o[0], sv_o[0]}, 255'b100);
    check("t5_z", z_o[0], '0);
    do_op(0, 255'd3, 255'd5, 255'd251, lat, busy, z);
    check("t5_z15", z, 255'd15);

    // 6: res_ready held high, zero multiplier
    do_op(0, 255'd0, 255'd123, 255'd251, lat, busy, z);
    check("t6_z0", z, '0);
    check("t6_pulse", {252'd0, rr_o[0], rb_o[0], sv_o[0]}, 255'b100);
    do_op(2, 255'd0, P - 255'd5, P, lat, busy, z);
    check("t6_z0_d5", z, '0);
    check("t6_pulse_d5", {252'd0, rr_o[2], rb_o[2], sv_o[2]}, 255'b100);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
